// File: rtl/encoder_16x4_hs_if.sv
// Handshake bundle for the 16-to-4 encoder: one-hot word in, encoded index out.
// slave is the encoder's view; master is the producer/consumer side.
interface encoder_16x4_hs_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_code;
  logic        out_zero;
  logic        out_multi;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_zero, out_multi
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_zero, out_multi
  );
endinterface

// File: rtl/encoder_16x4_hs.sv
// Registered 16-to-4 priority encoder behind a single-register valid/ready stage.
// Flags zero-hot and multi-hot words and keeps a saturating multi-hot count.
module encoder_16x4_hs #(
  parameter int unsigned PRIORITY_HIGH = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  encoder_16x4_hs_if.slave bus,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       in_ready;
  logic       load;
  logic [3:0] enc_code;
  logic       enc_zero;
  logic       enc_multi;
  logic [3:0] code_q;
  logic       zero_q;
  logic       multi_q;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  always_comb begin
    enc_code  = '0;
    enc_zero  = (bus.in_vec == '0);
    enc_multi = ((bus.in_vec & (bus.in_vec - 16'd1)) != '0);
    for (int unsigned i = 0; i < 16; i++) begin
      if (PRIORITY_HIGH != 0) begin
        if (bus.in_vec[i]) enc_code = 4'(i);
      end else begin
        if (bus.in_vec[15 - i]) enc_code = 4'(15 - i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = FULL;
      end
      FULL: begin
        in_ready = bus.out_ready;
        if (bus.out_ready && !bus.in_valid) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign load = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      zero_q  <= 1'b0;
      multi_q <= 1'b0;
    end else if (load) begin
      code_q  <= enc_code;
      zero_q  <= enc_zero;
      multi_q <= enc_multi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (load && enc_multi && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out_code  = code_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_multi = multi_q;

  out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable({code_q, zero_q, multi_q})));

endmodule
